// File: rtl/mux_8to1_scan_ctrl_pkg.sv
// Shared definitions for the mux_8to1 scan controller.
//   NCH    : number of mux channels scanned
//   SELW   : width of the channel select {s2,s1,s0}
//   state_t: controller states (ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE)
package mux_scan_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_8to1_scan_ctrl_if.sv
// Handshake/bus bundle between a scan requester and the scan controller.
//   start, mask : scan request and channel enables (requester -> controller)
//   y           : mux_8to1 output sampled by the controller
//   s2, s1, s0  : registered mux select (controller -> mux)
//   busy, done  : scan status; done pulses one cycle at scan end
//   frame       : result of the last completed scan
// Modports: master = requester/mux side, slave = controller side.
interface mux_8to1_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic           start;
    logic [NCH-1:0] mask;
    logic           y;
    logic           s2;
    logic           s1;
    logic           s0;
    logic           busy;
    logic           done;
    logic [NCH-1:0] frame;

    modport master (
        output start, mask, y,
        input  s2, s1, s0, busy, done, frame
    );

    modport slave (
        input  start, mask, y,
        output s2, s1, s0, busy, done, frame
    );

endinterface

// File: rtl/mux_8to1_scan_ctrl_next.sv
// mux_scan_next: combinational finder for the next enabled channel.
//   mask_q   : channel enable mask
//   cur_idx  : current channel index
//   first    : when set, cur_idx is ignored and the search covers all
//              channels (acts as a current index of -1)
//   found    : a qualifying channel exists
//   next_idx : lowest enabled channel strictly above cur_idx
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask_q,
    input  logic [SELW-1:0] cur_idx,
    input  logic            first,
    output logic            found,
    output logic [SELW-1:0] next_idx
);

    logic [NCH-1:0] cand;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        assign cand[gi] = mask_q[gi] & (first | (SELW'(gi) > cur_idx));
    end

    // Walk downward so the lowest candidate is the last one written.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found    = 1'b1;
                next_idx = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/mux_8to1_scan_ctrl.sv
// mux_8to1_scan_ctrl: steps the mux_8to1 select through the enabled
// channels in ascending order, samples y once per channel (after SETTLE
// extra wait cycles) and publishes the assembled 8-bit frame with a
// one-cycle done pulse.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of mux_8to1_scan_ctrl_if (start/mask/y in,
//         s2..s0/busy/done/frame out)
module mux_8to1_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_8to1_scan_ctrl_if.slave   bus
);

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);
    // State entered at the start of every channel.
    localparam state_t CH_ENTRY = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    state_t          state_reg;
    logic [SELW-1:0] sel_reg;
    logic [3:0]      wait_reg;
    logic [NCH-1:0]  mask_q_reg;
    logic [NCH-1:0]  shadow_reg;
    logic [NCH-1:0]  frame_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            first_found;
    logic [SELW-1:0] first_idx;
    logic            next_found;
    logic [SELW-1:0] next_idx;
    logic [NCH-1:0]  shadow_next;

    // Search the live mask at start time: mask_q is loaded on that edge.
    mux_scan_next u_find_first (
        .mask_q   (bus.mask),
        .cur_idx  ('0),
        .first    (1'b1),
        .found    (first_found),
        .next_idx (first_idx)
    );

    mux_scan_next u_find_next (
        .mask_q   (mask_q_reg),
        .cur_idx  (sel_reg),
        .first    (1'b0),
        .found    (next_found),
        .next_idx (next_idx)
    );

    always_comb begin
        shadow_next          = shadow_reg;
        shadow_next[sel_reg] = bus.y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= '0;
            wait_reg   <= '0;
            mask_q_reg <= '0;
            shadow_reg <= '0;
            frame_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        busy_reg   <= 1'b1;
                        shadow_reg <= '0;
                        if (first_found) begin
                            mask_q_reg <= bus.mask;
                            sel_reg    <= first_idx;
                            wait_reg   <= SETTLE_W;
                            state_reg  <= CH_ENTRY;
                        end else begin
                            // Empty scan: select untouched, empty frame.
                            frame_reg <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    wait_reg <= wait_reg - 4'd1;
                    if (wait_reg == 4'd1) begin
                        state_reg <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    shadow_reg <= shadow_next;
                    if (next_found) begin
                        sel_reg   <= next_idx;
                        wait_reg  <= SETTLE_W;
                        state_reg <= CH_ENTRY;
                    end else begin
                        frame_reg <= shadow_next;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s2    = sel_reg[2];
    assign bus.s1    = sel_reg[1];
    assign bus.s0    = sel_reg[0];
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.frame = frame_reg;

endmodule
